// File: rtl/dot_channel_seq_pkg.sv
// Shared definitions for the dot-channel sequencer: state encoding, index widths
// and the default channel result width.
package dot_channel_seq_pkg;

    localparam int CS_W         = 4;
    localparam int PHASE_W      = 3;
    localparam int DATA_LEN_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RUN  = 3'd2,
        ST_CAPT = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // True when (cs, phase) is the final pair of a sweep.
    function automatic logic is_last_pair(input logic [CS_W-1:0] cs,
                                          input logic [PHASE_W-1:0] phase,
                                          input int max_cs, input int max_phase);
        return (cs == CS_W'(max_cs - 1)) && (phase == PHASE_W'(max_phase - 1));
    endfunction

endpackage

// File: rtl/dot_seq_watchdog.sv
// RUN-state watchdog: counts RUN cycles and raises a sticky err when TIMEOUT
// cycles pass without channel valid. Only instantiated with DOT_SEQ_WATCHDOG_EN.
module dot_seq_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic ch_valid_i,
    input  logic abort_i,
    output logic timeout_o,
    output logic err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Counter sits at zero outside RUN, so every entry to RUN starts from zero.
    always_comb begin
        cnt_d     = run_i ? cnt_q + CW'(1) : '0;
        timeout_o = run_i && !ch_valid_i && !abort_i && (cnt_q == CW'(TIMEOUT - 1));
        err_d     = err_q | timeout_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/dot_channel_seq.sv
// Sequencer for one dot-product channel: sweeps every (cs, phase) pair, drives
// loads and d_req, captures tagged results. Watchdog enabled by DOT_SEQ_WATCHDOG_EN.
module dot_channel_seq
    import dot_channel_seq_pkg::*;
#(
    parameter int MAX_CS    = 9,
    parameter int MAX_PHASE = 4,
    parameter int TIMEOUT   = 64,
    parameter int DATA_LEN  = DATA_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                ch_valid_i,
    input  logic [DATA_LEN-1:0] ch_q_i,
    output logic                ws_load_o,
    output logic                dc_load_o,
    output logic [CS_W-1:0]     cs_o,
    output logic [PHASE_W-1:0]  phase_o,
    output logic                d_req_o,
    output logic                res_valid_o,
    output logic [DATA_LEN-1:0] res_q_o,
    output logic [CS_W-1:0]     res_cs_o,
    output logic [PHASE_W-1:0]  res_phase_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [2:0]          state_o
);

    state_e               state_q, state_d;
    logic [CS_W-1:0]      cs_q, cs_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [DATA_LEN-1:0]  res_q_q;
    logic [CS_W-1:0]      res_cs_q;
    logic [PHASE_W-1:0]   res_phase_q;
    logic                 capture;
    logic                 wd_timeout;

`ifdef DOT_SEQ_WATCHDOG_EN
    dot_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (state_q == ST_RUN),
        .ch_valid_i (ch_valid_i),
        .abort_i    (abort_i),
        .timeout_o  (wd_timeout),
        .err_o      (err_o)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign wd_timeout         = 1'b0;
    assign err_o              = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        phase_d = phase_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = ST_REQ;
                    cs_d    = '0;
                    phase_d = '0;
                end
            end
            ST_REQ:  state_d = ST_RUN;
            ST_RUN: begin
                if (wd_timeout) begin
                    state_d = ST_IDLE;
                    cs_d    = '0;
                    phase_d = '0;
                end else if (ch_valid_i) begin
                    state_d = ST_CAPT;
                    capture = 1'b1;
                end
            end
            ST_CAPT: state_d = ST_GAP;
            // Loads are low here for one cycle so the channel clears before the next pair.
            ST_GAP: begin
                if (is_last_pair(cs_q, phase_q, MAX_CS, MAX_PHASE)) begin
                    state_d = ST_DONE;
                    cs_d    = '0;
                    phase_d = '0;
                end else begin
                    state_d = ST_REQ;
                    if (phase_q == PHASE_W'(MAX_PHASE - 1)) begin
                        phase_d = '0;
                        cs_d    = cs_q + CS_W'(1);
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything, including a same-cycle channel valid.
        if (abort_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            cs_d    = '0;
            phase_d = '0;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cs_q        <= '0;
            phase_q     <= '0;
            res_q_q     <= '0;
            res_cs_q    <= '0;
            res_phase_q <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            phase_q <= phase_d;
            if (capture) begin
                res_q_q     <= ch_q_i;
                res_cs_q    <= cs_q;
                res_phase_q <= phase_q;
            end
        end
    end

    // Strobes decode straight from state so async reset clears them immediately.
    assign ws_load_o   = (state_q == ST_RUN);
    assign dc_load_o   = (state_q == ST_RUN);
    assign d_req_o     = (state_q == ST_REQ);
    assign res_valid_o = (state_q == ST_CAPT);
    assign done_o      = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign cs_o        = cs_q;
    assign phase_o     = phase_q;
    assign res_q_o     = res_q_q;
    assign res_cs_o    = res_cs_q;
    assign res_phase_o = res_phase_q;
    assign state_o     = state_q;

endmodule
